// File: rtl/chn_arb_pkg.sv
// Purpose: shared types and constants for the channel/endpoint arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: arbiter state encoding, a constant-evaluable clog2, default
// grant-timeout and hog-limit values.
package chn_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  localparam int GNT_TO_DEF  = 16;
  localparam int HOG_MAX_DEF = 1024;

  // Ceiling log2; usable in parameter/localparam expressions.
  function automatic int clog2(input int val);
    int res;
    res = 0;
    while ((1 << res) < val) res++;
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin picker over NCHN request bits.
// Latency: combinational, zero cycles.
// Backpressure: none; result is valid whenever any request bit is set.
// Ports: req - request vector; ptr - highest-priority index (< NCHN);
//        valid - any request; idx - first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int NCHN = 2,
  parameter int CW   = 3
) (
  input  logic [NCHN-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic            valid,
  output logic [CW-1:0]   idx
);

  // The upper copy of req supplies the wrapped-around candidates, so one
  // linear scan from ptr upwards covers every index exactly once.
  logic [2*NCHN-1:0] dbl;
  assign dbl = {req, req};

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the last hit (lowest position >= ptr) wins.
    for (int k = 2*NCHN-1; k >= 0; k--) begin
      if (dbl[k] && (k >= int'(ptr))) idx = CW'(k % NCHN);
    end
  end

endmodule

// File: rtl/chn_ep_arb.sv
// Purpose: round-robin owner of the endpoint TRN tx port shared by NCHN channels.
// Latency: request to turn grant is 1 cycle; one enforced idle (GAP) cycle between owners.
// Backpressure: a grant is held while the owner drives; unused grants are revoked after GNT_TO cycles.
// Ports: clk/rst (sync, active-high); chn_reqep/chn_drvn per-channel request and
//        driving flags; chn_trn one-hot turn grant; arb_owner last granted index;
//        arb_busy grant outstanding; err_hog/err_drv sticky protocol flags.
module chn_ep_arb
  import chn_arb_pkg::*;
#(
  parameter int NCHN    = 2,
  parameter int GNT_TO  = GNT_TO_DEF,
  parameter int HOG_MAX = HOG_MAX_DEF,
  parameter int CW      = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCHN-1:0] chn_reqep,
  input  logic [NCHN-1:0] chn_drvn,
  output logic [NCHN-1:0] chn_trn,
  output logic [CW-1:0]   arb_owner,
  output logic            arb_busy,
  output logic            err_hog,
  output logic            err_drv
);

  localparam int WW = clog2(GNT_TO) + 1;
  localparam int HW = clog2(HOG_MAX) + 1;

  arb_state_t    state;
  logic [CW-1:0] rr_ptr;
  logic [WW-1:0] wait_cnt;
  logic [HW-1:0] hog_cnt;

  logic          pick_vld;
  logic [CW-1:0] pick_idx;

  rr_pick #(
    .NCHN (NCHN),
    .CW   (CW)
  ) u_rr_pick (
    .req   (chn_reqep),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // In GRANT/BUSY chn_trn is exactly the owner's one-hot, so masking with it
  // selects the owner's request/drive bits without a variable-width index.
  logic own_drv;
  logic own_req;
  assign own_drv = |(chn_drvn & chn_trn);
  assign own_req = |(chn_reqep & chn_trn);

  // chn_trn is zero in IDLE/GAP, so "drvn outside chn_trn" covers both a
  // non-owner driving and anyone driving while no grant is outstanding.
  logic drv_multi;
  logic drv_bad;
  assign drv_multi = |(chn_drvn & (chn_drvn - NCHN'(1)));
  assign drv_bad   = drv_multi || (|(chn_drvn & ~chn_trn));

  logic [CW-1:0] next_ptr;
  assign next_ptr = (arb_owner == CW'(NCHN-1)) ? '0 : arb_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      hog_cnt   <= '0;
      chn_trn   <= '0;
      arb_owner <= '0;
      arb_busy  <= 1'b0;
      err_hog   <= 1'b0;
      err_drv   <= 1'b0;
    end else begin
      if (drv_bad) err_drv <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            chn_trn   <= NCHN'(1) << pick_idx;
            arb_owner <= pick_idx;
            arb_busy  <= 1'b1;
            wait_cnt  <= '0;
            state     <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (own_drv) begin
            hog_cnt <= '0;
            state   <= ST_BUSY;
          end else if (!own_req || (wait_cnt == WW'(GNT_TO-1))) begin
            // Release or revoke: the next search starts after this owner.
            chn_trn  <= '0;
            arb_busy <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= ST_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_BUSY: begin
          if (!own_drv) begin
            chn_trn  <= '0;
            arb_busy <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= ST_GAP;
          end else if (hog_cnt != HW'(HOG_MAX)) begin
            hog_cnt <= hog_cnt + 1'b1;
            if (hog_cnt == HW'(HOG_MAX-1)) err_hog <= 1'b1;
          end
        end

        ST_GAP: begin
          // Guaranteed turnaround cycle on TRN tx.
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chn_ep_arb.sv
module tb_chn_ep_arb;

  localparam int NCHN    = 2;
  localparam int CW      = 3;
  localparam int GNT_TO  = 16;
  localparam int HOG_MAX = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCHN-1:0] chn_reqep;
  logic [NCHN-1:0] chn_drvn;
  logic [NCHN-1:0] chn_trn;
  logic [CW-1:0]   arb_owner;
  logic            arb_busy;
  logic            err_hog;
  logic            err_drv;

  chn_ep_arb #(
    .NCHN    (NCHN),
    .GNT_TO  (GNT_TO),
    .HOG_MAX (HOG_MAX),
    .CW      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .chn_reqep (chn_reqep),
    .chn_drvn  (chn_drvn),
    .chn_trn   (chn_trn),
    .arb_owner (arb_owner),
    .arb_busy  (arb_busy),
    .err_hog   (err_hog),
    .err_drv   (err_drv)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of one channel's tenure on the bus.
  localparam int PH_IDLE  = 0;  // nobody holds a turn
  localparam int PH_OFFER = 1;  // turn offered, owner not yet driving
  localparam int PH_DRIVE = 2;  // owner driving
  localparam int PH_GAP   = 3;  // turnaround cycle

  int              m_phase;
  int              m_ptr;
  int              m_age;   // edges since the turn was offered
  int              m_run;   // consecutive sampled drvn cycles of the owner
  logic [NCHN-1:0] e_trn;
  int              e_owner;
  logic            e_busy;
  logic            e_hog;
  logic            e_drv;

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_ptr   = 0;
    m_age   = 0;
    m_run   = 0;
    e_trn   = '0;
    e_owner = 0;
    e_busy  = 1'b0;
    e_hog   = 1'b0;
    e_drv   = 1'b0;
  endtask

  task automatic end_tenure();
    e_trn   = '0;
    e_busy  = 1'b0;
    m_ptr   = (e_owner + 1) % NCHN;
    m_phase = PH_GAP;
  endtask

  task automatic model_step();
    bit found;
    int c;
    int o;
    if (rst) begin
      model_reset();
      return;
    end
    o = e_owner;
    if ($countones(chn_drvn) > 1) e_drv = 1'b1;
    for (int j = 0; j < NCHN; j++)
      if (chn_drvn[j] && !((m_phase == PH_OFFER || m_phase == PH_DRIVE) && j == o)) e_drv = 1'b1;
    case (m_phase)
      PH_IDLE: begin
        found = 1'b0;
        for (int k = 0; k < NCHN; k++) begin
          c = (m_ptr + k) % NCHN;
          if (!found && chn_reqep[c]) begin
            found    = 1'b1;
            e_trn    = '0;
            e_trn[c] = 1'b1;
            e_owner  = c;
            e_busy   = 1'b1;
            m_age    = 0;
            m_phase  = PH_OFFER;
          end
        end
      end
      PH_OFFER: begin
        if (chn_drvn[o]) begin
          m_phase = PH_DRIVE;
          m_run   = 1;
        end else begin
          m_age++;
          if (!chn_reqep[o] || m_age >= GNT_TO) end_tenure();
        end
      end
      PH_DRIVE: begin
        if (chn_drvn[o]) begin
          m_run++;
          if (m_run > HOG_MAX) e_hog = 1'b1;
        end else begin
          end_tenure();
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  // One clock: model consumes the same inputs the DUT samples, then compare.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("trn",    32'(chn_trn),   32'(e_trn));
    chk("owner",  32'(arb_owner), 32'(e_owner));
    chk("busy",   32'(arb_busy),  32'(e_busy));
    chk("hog",    32'(err_hog),   32'(e_hog));
    chk("drverr", 32'(err_drv),   32'(e_drv));
    chk("onehot", 32'($countones(chn_trn) <= 1), 32'(1));
  endtask

  task automatic rst_pulse();
    rst = 1'b1; chn_reqep = '0; chn_drvn = '0;
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a grant, check its latency and owner, drive ndrv cycles, release.
  task automatic serve(input int ch, input int ndrv, input int exp_lat, input string tag);
    int steps;
    steps = 0;
    while (chn_trn == '0 && steps < 40) begin
      step();
      steps++;
    end
    chk({tag, "_lat"},   32'(steps),     32'(exp_lat));
    chk({tag, "_owner"}, 32'(arb_owner), 32'(ch));
    chn_drvn = NCHN'(1) << ch;
    repeat (ndrv) step();
    chn_drvn = '0;
    step();
    chk({tag, "_drop"}, 32'(chn_trn), 32'(0));
  endtask

  int              left [NCHN];
  bit              used [NCHN];
  logic [NCHN-1:0] r_req;
  logic [NCHN-1:0] r_drv;
  int              steps;

  initial begin
    model_reset();
    rst = 1'b1; chn_reqep = '0; chn_drvn = '0;
    step(); step();
    chk("rst_trn",   32'(chn_trn),   32'(0));
    chk("rst_owner", 32'(arb_owner), 32'(0));
    chk("rst_busy",  32'(arb_busy),  32'(0));
    chk("rst_errs",  32'({err_hog, err_drv}), 32'(0));
    rst = 1'b0;

    // Single request, 3 driving cycles, release, GAP.
    chn_reqep = 2'b01;
    step();
    chk("single_grant", 32'(chn_trn), 32'(1));
    chn_drvn = 2'b01;
    repeat (3) step();
    chn_drvn = '0; chn_reqep = '0;
    step();
    chk("single_drop", 32'(chn_trn), 32'(0));
    chk("single_gap_busy", 32'(arb_busy), 32'(0));
    step();

    // Round robin with both channels requesting continuously.
    rst_pulse();
    chn_reqep = 2'b11;
    serve(0, 4, 1, "rr0");
    serve(1, 4, 2, "rr1");
    serve(0, 4, 2, "rr2");
    serve(1, 4, 2, "rr3");
    chn_reqep = '0;
    step(); step();

    // Grant timeout: channel 1 never drives, channel 0 waits.
    rst_pulse();
    chn_reqep = 2'b10;
    step();
    chk("to_grant", 32'(chn_trn), 32'(2));
    chn_reqep = 2'b11;
    steps = 0;
    while (chn_trn[1] && steps < 40) begin step(); steps++; end
    chk("to_revoke_lat", 32'(steps), 32'(GNT_TO));
    steps = 0;
    while (chn_trn == '0 && steps < 40) begin step(); steps++; end
    chk("to_next_lat", 32'(steps), 32'(2));
    chk("to_next_trn", 32'(chn_trn), 32'(1));
    chn_reqep = '0;
    step(); step();

    // Hog monitor: 10 driving cycles with HOG_MAX=8.
    rst_pulse();
    chn_reqep = 2'b01;
    step();
    chn_drvn = 2'b01;
    repeat (HOG_MAX) step();
    chk("hog_early", 32'(err_hog), 32'(0));
    repeat (2) step();
    chk("hog_set", 32'(err_hog), 32'(1));
    chk("hog_hold_trn", 32'(chn_trn), 32'(1));
    chn_drvn = '0; chn_reqep = '0;
    step();
    chk("hog_drop", 32'(chn_trn), 32'(0));
    step();
    chk("hog_sticky", 32'(err_hog), 32'(1));

    // Protocol violation while channel 0 owns the bus.
    rst_pulse();
    chn_reqep = 2'b01;
    step();
    chn_drvn = 2'b01;
    step();
    chn_drvn = 2'b11;
    step();
    chk("viol_set", 32'(err_drv), 32'(1));
    chk("viol_trn", 32'(chn_trn), 32'(1));
    chn_drvn = 2'b01;
    step();
    chk("viol_trn_cont", 32'(chn_trn), 32'(1));
    chn_drvn = '0; chn_reqep = '0;
    step(); step();
    chk("viol_sticky", 32'(err_drv), 32'(1));

    // Reset in the middle of channel 1's drive burst.
    rst_pulse();
    chn_reqep = 2'b10;
    step();
    chn_drvn = 2'b10;
    step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_trn",   32'(chn_trn),   32'(0));
    chk("mid_rst_owner", 32'(arb_owner), 32'(0));
    chk("mid_rst_busy",  32'(arb_busy),  32'(0));
    rst = 1'b0; chn_drvn = '0; chn_reqep = 2'b11;
    step();
    chk("mid_rst_ch0_first", 32'(chn_trn), 32'(1));

    // Randomized traffic against the model.
    rst_pulse();
    for (int c = 0; c < NCHN; c++) begin left[c] = 0; used[c] = 1'b0; end
    r_req = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r_drv = '0;
      for (int c = 0; c < NCHN; c++) begin
        if (e_trn[c]) begin
          if (left[c] > 0) begin
            r_drv[c] = 1'b1;
            left[c]--;
          end else if (!used[c] && ($urandom % 3 == 0)) begin
            left[c]  = $urandom_range(12, 1) - 1;
            r_drv[c] = 1'b1;
            used[c]  = 1'b1;
          end
          if ($urandom % 20 == 0) r_req[c] = 1'b0;
        end else begin
          used[c] = 1'b0;
          left[c] = 0;
          if ($urandom % 4 == 0) r_req[c] = ~r_req[c];
        end
      end
      if ($urandom % 100 == 0) r_drv[$urandom % NCHN] = 1'b1;
      rst       = ($urandom % 500 == 0);
      chn_reqep = r_req;
      chn_drvn  = r_drv;
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
